// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a six-digit seven-segment bank.
// Snapshots the six ALU segment patterns once per frame (no mid-scan tearing)
// and scans them onto a shared segment bus, one digit per CLK_DIV-clock slot.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous, active-high reset
//   display0..display5   7-bit active-low segment patterns (display0 = rightmost)
//   hold                 skip the frame-boundary snapshot, keep previous shadow
//   segments             registered active-low segment bus
//   digit_sel            registered active-low one-hot digit enables
//   frame_done           one-cycle pulse after digit 5's slot ends
//
// Optional feature: define SEG_SCAN_BLANK_EN to blank the first BLANK_CYCLES
// clocks of every slot (anti-ghosting). Without it BLANK_CYCLES is ignored.
module seg_scan_driver #(
   parameter int unsigned CLK_DIV      = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] display0,
   input  logic [6:0] display1,
   input  logic [6:0] display2,
   input  logic [6:0] display3,
   input  logic [6:0] display4,
   input  logic [6:0] display5,
   input  logic       hold,
   output logic [6:0] segments,
   output logic [5:0] digit_sel,
   output logic       frame_done
);

   localparam int unsigned CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned NUM_DIGITS = 6;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;
   localparam logic [5:0]       SEL_OFF  = 6'h3F;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [SEG_W-1:0] shadow_q [NUM_DIGITS];
   logic [SEG_W-1:0] shadow_d [NUM_DIGITS];
   logic [SEG_W-1:0] display_c [NUM_DIGITS];
   logic             load_pending_q, load_pending_d;
   logic [SEG_W-1:0] segments_q, segments_d;
   logic [5:0]       digit_sel_q, digit_sel_d;
   logic             frame_done_q, frame_done_d;

   logic tick_c;
   logic wrap_c;
   logic load_due_c;
   logic blank_c;

   assign display_c[0] = display0;
   assign display_c[1] = display1;
   assign display_c[2] = display2;
   assign display_c[3] = display3;
   assign display_c[4] = display4;
   assign display_c[5] = display5;

   // Blanking window at the start of each slot (only when the feature is built)
`ifdef SEG_SCAN_BLANK_EN
   assign blank_c = (cnt_q < CNT_W'(BLANK_CYCLES));
`else
   logic [31:0] unused_blank_cycles;
   assign unused_blank_cycles = BLANK_CYCLES;
   assign blank_c = 1'b0;
`endif

   // Next-state: prescaler, digit index, snapshot and registered outputs
   always_comb begin
      cnt_d          = cnt_q + CNT_W'(1);
      idx_d          = idx_q;
      shadow_d       = shadow_q;
      load_pending_d = load_pending_q;
      segments_d     = shadow_q[idx_q];
      digit_sel_d    = ~(6'b00_0001 << idx_q);
      frame_done_d   = 1'b0;

      tick_c     = (cnt_q == CNT_MAX);
      wrap_c     = tick_c && (idx_q == IDX_LAST);
      // A wrap coinciding with a pending load still yields a single load
      load_due_c = wrap_c || load_pending_q;

      if (tick_c) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end

      // hold only matters on load-due cycles; the pending flag clears regardless
      if (load_due_c) begin
         load_pending_d = 1'b0;
         if (!hold) begin
            shadow_d = display_c;
         end
      end

      if (blank_c) begin
         segments_d  = SEG_OFF;
         digit_sel_d = SEL_OFF;
      end

      frame_done_d = wrap_c;
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q          <= '0;
         idx_q          <= '0;
         load_pending_q <= 1'b1;
         segments_q     <= SEG_OFF;
         digit_sel_q    <= SEL_OFF;
         frame_done_q   <= 1'b0;
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            shadow_q[i] <= SEG_OFF;
         end
      end else begin
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         load_pending_q <= load_pending_d;
         segments_q     <= segments_d;
         digit_sel_q    <= digit_sel_d;
         frame_done_q   <= frame_done_d;
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign segments   = segments_q;
   assign digit_sel  = digit_sel_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed + scoreboard bench for seg_scan_driver
// (CLK_DIV = 4, BLANK_CYCLES = 1). Follows SEG_SCAN_BLANK_EN like the RTL.
module tb_seg_scan_driver;

`ifdef SEG_SCAN_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       hold;
   logic [6:0] d [6];
   logic [6:0] segments;
   logic [5:0] digit_sel;
   logic       frame_done;

   int checks = 0;
   int errors = 0;
   int kc     = 0;

   // Behavioural reference state
   int         m_cnt;
   int         m_idx;
   logic [6:0] m_sh [6];
   bit         m_pend;
   logic [13:0] sb [$];

   logic [5:0] sel_tab [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

   seg_scan_driver #(.CLK_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .display0   (d[0]),
      .display1   (d[1]),
      .display2   (d[2]),
      .display3   (d[3]),
      .display4   (d[4]),
      .display5   (d[5]),
      .hold       (hold),
      .segments   (segments),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, kc);
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_idx  = 0;
      m_pend = 1'b1;
      for (int i = 0; i < 6; i++) m_sh[i] = 7'h7F;
      sb.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_seg"}, 32'(segments), 32'h7F);
      chk({tag, "_sel"}, 32'(digit_sel), 32'h3F);
      chk({tag, "_fd"},  32'(frame_done), 32'h0);
   endtask

   // One clock: push the expected registered outputs, advance, pop and compare
   task automatic cyc();
      logic [13:0] e;
      logic        bl;
      logic        load;
      bl = BLANK && (m_cnt == 0);
      e[13:7] = bl ? 7'h7F : m_sh[m_idx];
      e[6:1]  = bl ? 6'h3F : sel_tab[m_idx];
      e[0]    = (m_cnt == 3) && (m_idx == 5);
      sb.push_back(e);
      load = ((m_cnt == 3) && (m_idx == 5)) || m_pend;
      if (load && !hold) m_sh = d;
      if (load) m_pend = 1'b0;
      if (m_cnt == 3) begin
         m_cnt = 0;
         m_idx = (m_idx == 5) ? 0 : m_idx + 1;
      end else begin
         m_cnt++;
      end
      @(posedge clk);
      #1;
      kc++;
      e = sb.pop_front();
      chk("sb_seg", 32'(segments), 32'(e[13:7]));
      chk("sb_sel", 32'(digit_sel), 32'(e[6:1]));
      chk("sb_fd",  32'(frame_done), 32'(e[0]));
      chk("sel_onehot_low",
          32'(($countones(~digit_sel) == 1) || (BLANK && digit_sel == 6'h3F)), 32'h1);
   endtask

   task automatic run_to(input int n);
      while (kc < n) cyc();
   endtask

   initial begin
      logic [5:0] sel_exp;
      logic [6:0] seg_exp;
      bit         bl;
      int         ix;

      reset = 1'b1;
      hold  = 1'b0;
      for (int i = 0; i < 6; i++) d[i] = 7'(7'h40 + i);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("por");
      reset = 1'b0;
      kc    = 0;

      // Scan order over two frames against fixed constants
      for (int k = 1; k <= 48; k++) begin
         cyc();
         ix      = ((k - 1) / 4) % 6;
         bl      = BLANK && ((k - 1) % 4 == 0);
         sel_exp = bl ? 6'h3F : sel_tab[ix];
         seg_exp = (bl || k == 1) ? 7'h7F : 7'(7'h40 + ix);
         chk("scan_sel", 32'(digit_sel), 32'(sel_exp));
         chk("scan_seg", 32'(segments), 32'(seg_exp));
         chk("scan_fd", 32'(frame_done), 32'((k % 24) == 0));
      end

      // No tearing: change digit 3 while digit 1 is being scanned
      run_to(52);
      d[3] = 7'h00;
      run_to(62);
      chk("tear_old", 32'(segments), 32'h43);
      run_to(86);
      chk("tear_new", 32'(segments), 32'h00);

      // Hold across a frame boundary while all inputs change
      hold = 1'b1;
      for (int i = 0; i < 6; i++) d[i] = 7'(7'h10 + i);
      run_to(98);
      chk("hold_d0_old", 32'(segments), 32'h40);
      run_to(100);
      hold = 1'b0;
      run_to(110);
      chk("hold_d3_old", 32'(segments), 32'h00);
      run_to(122);
      chk("hold_d0_new", 32'(segments), 32'h10);
      run_to(134);
      chk("hold_d3_new", 32'(segments), 32'h13);

      // Reset asserted mid-slot, then restart
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_async");
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst_held");
      reset = 1'b0;
      kc    = 0;
      run_to(1);
      chk("rst_rel_sel", 32'(digit_sel), BLANK ? 32'h3F : 32'h3E);
      run_to(2);
      chk("rst_rel_seg", 32'(segments), 32'h10);
      chk("rst_rel_sel2", 32'(digit_sel), 32'h3E);

      // 100 frames with random inputs and hold
      for (int c = 0; c < 2400; c++) begin
         if (c % 7 == 0) begin
            for (int i = 0; i < 6; i++) d[i] = 7'($urandom_range(0, 127));
            hold = ($urandom_range(0, 3) == 0);
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
